// File: rtl/perf_counter_sampler_pkg.sv
// Shared debug types for the performance counter block and its window sampler.
// Both blocks import these constants so their counter count and width agree.
package perf_counter_sampler_pkg;

  localparam int NUM_PERF_COUNTERS  = 7;
  localparam int PERF_COUNTER_WIDTH = 32;
  localparam int PERF_WINDOW_WIDTH  = 24;
  localparam int PERF_SEQ_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } PerfSamplerState;

  typedef logic [$clog2(NUM_PERF_COUNTERS)-1:0] PerfCounterIndex;

endpackage

// File: rtl/perf_sampler_window_timer.sv
// Window countdown for the sampler: loads window-1 (a zero window acts as one cycle),
// counts down while running, and can reload the latched window for periodic sampling.
module perf_sampler_window_timer #(
  parameter int WINDOW_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    reload,
  input  logic                    run,
  input  logic [WINDOW_WIDTH-1:0] window,
  output logic                    zero
);

  logic [WINDOW_WIDTH-1:0] window_clamped;
  logic [WINDOW_WIDTH-1:0] window_q;
  logic [WINDOW_WIDTH-1:0] count_q;

  assign window_clamped = (window == '0) ? WINDOW_WIDTH'(1) : window;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      window_q <= window_clamped;
      count_q  <= window_clamped - WINDOW_WIDTH'(1);
    end else if (reload) begin
      count_q <= window_q - WINDOW_WIDTH'(1);
    end else if (run && count_q != '0) begin
      count_q <= count_q - WINDOW_WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/perf_counter_sampler.sv
// Windowed sampler: baselines all live counters, snapshots deltas after the window,
// then streams one delta per handshake, once or periodically.
module perf_counter_sampler
  import perf_counter_sampler_pkg::*;
#(
  parameter int NUM_COUNTERS  = NUM_PERF_COUNTERS,
  parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH,
  parameter int WINDOW_WIDTH  = PERF_WINDOW_WIDTH,
  parameter int SEQ_WIDTH     = PERF_SEQ_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfgStart,
  input  logic                                  cfgStop,
  input  logic [WINDOW_WIDTH-1:0]               cfgWindow,
  input  logic                                  cfgPeriodic,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counterValue,
  output logic                                  outValid,
  input  logic                                  outReady,
  output logic [$clog2(NUM_COUNTERS)-1:0]       outIndex,
  output logic [COUNTER_WIDTH-1:0]              outDelta,
  output logic [SEQ_WIDTH-1:0]                  outSeq,
  output logic                                  busy,
  output logic                                  sampleDone
);

  localparam int IDX_W = $clog2(NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

  PerfSamplerState state_q, state_d;

  logic [COUNTER_WIDTH-1:0] base_q  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] delta_q [NUM_COUNTERS];
  logic [IDX_W-1:0]         idx_q;
  logic [SEQ_WIDTH-1:0]     seq_q;
  logic                     periodic_q;
  logic                     done_q;
  logic                     timer_zero;

  logic start_fire, snap_fire, accept, last_accept;

  // Stop overrides every other event, so it is folded into each qualifier.
  always_comb begin
    start_fire  = (state_q == IDLE) && cfgStart && !cfgStop;
    snap_fire   = (state_q == RUN) && timer_zero && !cfgStop;
    accept      = (state_q == DRAIN) && outReady && !cfgStop;
    last_accept = accept && (idx_q == LAST_IDX);
  end

  perf_sampler_window_timer #(
    .WINDOW_WIDTH(WINDOW_WIDTH)
  ) u_window_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_fire),
    .reload(last_accept && periodic_q),
    .run   (state_q == RUN),
    .window(cfgWindow),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_fire)  state_d = RUN;
      RUN:     if (snap_fire)   state_d = DRAIN;
      DRAIN:   if (last_accept) state_d = periodic_q ? RUN : IDLE;
      default:                  state_d = IDLE;
    endcase
    if (cfgStop) state_d = IDLE;
  end

  // NOTE: the base/delta arrays are flop-based and must read as zero after reset, so they are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        base_q[i]  <= '0;
        delta_q[i] <= '0;
      end
      idx_q      <= '0;
      seq_q      <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_accept;
      if (start_fire) begin
        periodic_q <= cfgPeriodic;
        for (int i = 0; i < NUM_COUNTERS; i++)
          base_q[i] <= counterValue[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
      // Modular subtraction gives the right delta across a counter wrap.
      if (snap_fire) begin
        idx_q <= '0;
        for (int i = 0; i < NUM_COUNTERS; i++)
          delta_q[i] <= counterValue[i*COUNTER_WIDTH +: COUNTER_WIDTH] - base_q[i];
      end
      if (accept) begin
        if (idx_q != LAST_IDX) begin
          idx_q <= idx_q + IDX_W'(1);
        end else begin
          seq_q <= seq_q + SEQ_WIDTH'(1);
          if (periodic_q) begin
            for (int i = 0; i < NUM_COUNTERS; i++)
              base_q[i] <= counterValue[i*COUNTER_WIDTH +: COUNTER_WIDTH];
          end
        end
      end
    end
  end

  assign outValid   = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign outIndex   = idx_q;
  assign outDelta   = delta_q[idx_q];
  assign outSeq     = seq_q;
  assign sampleDone = done_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: a timestamp-based window model checks every cycle,
// directed scenarios pin literal values, then a randomized soak runs against the model.
module tb_perf_counter_sampler;

  localparam int N  = 7;
  localparam int W  = 32;
  localparam int WW = 24;
  localparam int SW = 8;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfgStart = 1'b0;
  logic              cfgStop = 1'b0;
  logic [WW-1:0]     cfgWindow = '0;
  logic              cfgPeriodic = 1'b0;
  logic [N*W-1:0]    counterValue = '0;
  logic              outValid;
  logic              outReady = 1'b1;
  logic [IW-1:0]     outIndex;
  logic [W-1:0]      outDelta;
  logic [SW-1:0]     outSeq;
  logic              busy;
  logic              sampleDone;

  always #5 clk = ~clk;

  perf_counter_sampler #(
    .NUM_COUNTERS (N),
    .COUNTER_WIDTH(W),
    .WINDOW_WIDTH (WW),
    .SEQ_WIDTH    (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfgStart    (cfgStart),
    .cfgStop     (cfgStop),
    .cfgWindow   (cfgWindow),
    .cfgPeriodic (cfgPeriodic),
    .counterValue(counterValue),
    .outValid    (outValid),
    .outReady    (outReady),
    .outIndex    (outIndex),
    .outDelta    (outDelta),
    .outSeq      (outSeq),
    .busy        (busy),
    .sampleDone  (sampleDone)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus state: live counters and per-cycle increments.
  logic [W-1:0] cnt [N];
  logic [W-1:0] inc [N];
  bit           rnd_cnt   = 0;
  bit           rnd_ready = 0;

  task automatic pack();
    for (int i = 0; i < N; i++) counterValue[i*W +: W] = cnt[i];
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      cnt[i] = cnt[i] + inc[i];
      if (rnd_cnt) begin
        cnt[i] = cnt[i] + W'($urandom_range(0, 3));
        if ($urandom_range(0, 63) == 0) cnt[i] = $urandom();
      end
    end
    pack();
    if (rnd_ready) outReady = $urandom_range(0, 1) == 1;
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) begin
      cnt[i] = v;
      inc[i] = '0;
    end
    pack();
  endtask

  task automatic pulse_start(input int w, input bit per);
    cfgWindow   = WW'(w);
    cfgPeriodic = per;
    cfgStart    = 1'b1;
    cycle();
    cfgStart    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cfgStart = 1'b0;
    cfgStop  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout_busy", busy, 0);
    cycle();
  endtask

  // Behavioural model: a window is a pair of edge timestamps; deltas are plain subtraction.
  longint       edge_no = 0;
  longint       m_snap_at = 0;
  logic [W-1:0] m_base  [N];
  logic [W-1:0] m_delta [N];
  bit           m_busy = 0, m_drain = 0, m_done = 0, m_per = 0;
  int           m_idx = 0, m_seq = 0, m_w = 1;

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_done = 0; m_per = 0;
    m_idx = 0; m_seq = 0; m_w = 1;
    for (int i = 0; i < N; i++) begin
      m_base[i]  = '0;
      m_delta[i] = '0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] cur [N];
    for (int i = 0; i < N; i++) cur[i] = counterValue[i*W +: W];
    edge_no++;
    m_done = 0;
    if (cfgStop) begin
      m_busy  = 0;
      m_drain = 0;
    end else if (!m_busy) begin
      if (cfgStart) begin
        m_w       = (cfgWindow == '0) ? 1 : int'(cfgWindow);
        m_per     = cfgPeriodic;
        m_base    = cur;
        m_snap_at = edge_no + m_w;
        m_busy    = 1;
      end
    end else if (!m_drain) begin
      if (edge_no == m_snap_at) begin
        for (int i = 0; i < N; i++) m_delta[i] = cur[i] - m_base[i];
        m_drain = 1;
        m_idx   = 0;
      end
    end else if (outReady) begin
      if (m_idx < N - 1) begin
        m_idx++;
      end else begin
        m_done  = 1;
        m_seq   = (m_seq + 1) % (1 << SW);
        m_drain = 0;
        if (m_per) begin
          m_base    = cur;
          m_snap_at = edge_no + m_w;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare process plus a log of accepted entries for the literal checks.
  int           log_idx[$];
  int           log_seq[$];
  logic [W-1:0] log_delta[$];
  int           done_cnt = 0;
  int           cyc = 0, last6_cyc = -10, done_cyc = -20;

  task automatic clear_log();
    log_idx.delete();
    log_seq.delete();
    log_delta.delete();
    done_cnt = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        check("busy", busy, m_busy);
        check("outValid", outValid, m_drain);
        check("sampleDone", sampleDone, m_done);
        if (m_drain) begin
          check("outIndex", outIndex, m_idx);
          check("outDelta", outDelta, m_delta[m_idx]);
          check("outSeq", outSeq, m_seq);
        end
        if (outValid && outReady) begin
          log_idx.push_back(int'(outIndex));
          log_seq.push_back(int'(outSeq));
          log_delta.push_back(outDelta);
          if (int'(outIndex) == N - 1) last6_cyc = cyc;
        end
        if (sampleDone) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  held, dropped, hit;
    set_all('0);

    // Reset values.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_outValid", outValid, 0);
    check("rst_sampleDone", sampleDone, 0);
    check("rst_outIndex", outIndex, 0);
    check("rst_outDelta", outDelta, 0);
    check("rst_outSeq", outSeq, 0);

    // Single shot, window 10, counter 2 counts every cycle.
    set_all(32'd100);
    inc[2] = 1;
    outReady = 1'b1;
    clear_log();
    pulse_start(10, 0);
    run_until_idle(100);
    check("single_count", log_idx.size(), 7);
    for (int k = 0; k < log_idx.size(); k++) begin
      check("single_idx", log_idx[k], k);
      check("single_delta", log_delta[k], (k == 2) ? 10 : 0);
      check("single_seq", log_seq[k], 0);
    end
    check("single_done_cnt", done_cnt, 1);
    check("single_done_timing", done_cyc, last6_cyc + 1);
    check("single_busy_after", busy, 0);

    // Counter wrap: base 0xFFFFFFFE, +5 over a 4-cycle window.
    set_all(32'hFFFF_FFFE);
    clear_log();
    inc[0] = 2;
    pulse_start(4, 0);
    inc[0] = 1;
    repeat (3) cycle();
    inc[0] = 0;
    run_until_idle(100);
    check("wrap_count", log_idx.size(), 7);
    if (log_delta.size() > 0) check("wrap_delta0", log_delta[0], 5);

    // Backpressure on idx 3.
    set_all(32'd1000);
    for (int i = 0; i < N; i++) inc[i] = W'(i + 1);
    clear_log();
    pulse_start(6, 0);
    held = 0;
    n = 0;
    while (busy && n < 200) begin
      if (outValid && outIndex == 3 && !held) begin
        outReady = 1'b0;
        repeat (3) begin
          cycle();
          check("bp_valid", outValid, 1);
          check("bp_idx", outIndex, 3);
          check("bp_delta", outDelta, 24);
        end
        outReady = 1'b1;
        held = 1;
      end
      cycle();
      n++;
    end
    cycle();
    check("bp_held_seen", held, 1);
    check("bp_accepts", log_idx.size(), 7);
    for (int k = 0; k < log_idx.size(); k++) begin
      check("bp_order", log_idx[k], k);
      check("bp_delta_log", log_delta[k], 6 * (k + 1));
    end

    // Periodic, window 5, three windows.
    do_reset();
    set_all(32'd7);
    inc[4] = 1;
    clear_log();
    pulse_start(5, 1);
    dropped = 0;
    n = 0;
    while (done_cnt < 3 && n < 300) begin
      cycle();
      if (!busy) dropped = 1;
      n++;
    end
    check("per_windows", done_cnt, 3);
    check("per_busy_dropped", dropped, 0);
    cfgStop = 1'b1;
    cycle();
    cfgStop = 1'b0;
    check("per_stop_busy", busy, 0);
    n = 0;
    for (int k = 0; k < log_idx.size(); k++) begin
      if (log_idx[k] == 4) begin
        check("per_delta", log_delta[k], 5);
        check("per_seq", log_seq[k], n);
        n++;
      end
    end
    check("per_idx4_count", n, 3);

    // Abort during DRAIN at idx 4.
    do_reset();
    set_all(32'd0);
    inc[1] = 1;
    clear_log();
    pulse_start(3, 0);
    n = 0;
    while (!(outValid && outIndex == 4) && n < 100) begin
      cycle();
      n++;
    end
    hit = outValid && outIndex == 4;
    check("abort_reached_idx4", hit, 1);
    cfgStop = 1'b1;
    cycle();
    cfgStop = 1'b0;
    check("abort_valid", outValid, 0);
    check("abort_busy", busy, 0);
    check("abort_seq", outSeq, 0);
    cycle();
    check("abort_no_done", done_cnt, 0);
    clear_log();
    pulse_start(3, 0);
    run_until_idle(100);
    if (log_seq.size() > 0) check("abort_seq_reuse", log_seq[0], 0);
    check("abort_restart_done", done_cnt, 1);

    // Zero window behaves as one cycle.
    do_reset();
    set_all(32'd50);
    inc[5] = 1;
    clear_log();
    pulse_start(0, 0);
    check("w0_busy", busy, 1);
    check("w0_valid_early", outValid, 0);
    cycle();
    check("w0_valid", outValid, 1);
    check("w0_idx", outIndex, 0);
    run_until_idle(100);
    check("w0_count", log_idx.size(), 7);
    if (log_delta.size() == 7) check("w0_delta5", log_delta[5], 1);

    // Start while busy is ignored.
    clear_log();
    pulse_start(8, 0);
    cycle();
    pulse_start(2, 0);
    n = 2;
    while (!outValid && n < 50) begin
      cycle();
      n++;
    end
    check("busy_start_len", n, 8);
    run_until_idle(100);
    check("busy_start_count", log_idx.size(), 7);
    if (log_delta.size() == 7) check("busy_start_delta5", log_delta[5], 8);

    // Asynchronous reset in RUN.
    pulse_start(10, 0);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", outValid, 0);
    check("arst_done", sampleDone, 0);
    check("arst_idx", outIndex, 0);
    check("arst_delta", outDelta, 0);
    check("arst_seq", outSeq, 0);

    // Randomized soak against the model.
    do_reset();
    set_all(32'd0);
    rnd_cnt   = 1;
    rnd_ready = 1;
    for (int t = 0; t < 3000; t++) begin
      cfgStart    = $urandom_range(0, 7) == 0;
      cfgStop     = $urandom_range(0, 60) == 0;
      cfgWindow   = ($urandom_range(0, 9) == 0) ? '0 : WW'($urandom_range(1, 6));
      cfgPeriodic = $urandom_range(0, 1) == 1;
      cycle();
    end
    cfgStart  = 1'b0;
    cfgStop   = 1'b1;
    cycle();
    cfgStop   = 1'b0;
    rnd_cnt   = 0;
    rnd_ready = 0;
    outReady  = 1'b1;
    cycle();
    check("soak_end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
